// File: rtl/lru_tracker_nway.sv
// lru_tracker_nway: per-set true-LRU list of {valid, dirty, tag} with lookup, promotion,
// fill with victim report, and a full flush that offers dirty lines on a valid/ready port.
module lru_tracker_nway #(
   parameter int WAYS  = 4,
   parameter int DEPTH = 64,
   parameter int TAG_W = 8,
   parameter int IDX_W = $clog2(DEPTH),
   parameter int POS_W = $clog2(WAYS)
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             lk_en,
   input  logic [IDX_W-1:0] lk_idx,
   input  logic [TAG_W-1:0] lk_tag,
   output logic             lk_vld,
   output logic             lk_hit,
   output logic [POS_W-1:0] lk_pos,
   input  logic             touch_en,
   input  logic [IDX_W-1:0] touch_idx,
   input  logic [POS_W-1:0] touch_pos,
   input  logic             touch_wr,
   input  logic             fill_en,
   input  logic [IDX_W-1:0] fill_idx,
   input  logic [TAG_W-1:0] fill_tag,
   input  logic             fill_dirty,
   output logic             vic_vld,
   output logic             vic_valid,
   output logic             vic_dirty,
   output logic [TAG_W-1:0] vic_tag,
   input  logic             flush_req,
   output logic             busy,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [IDX_W-1:0] wb_idx,
   output logic [TAG_W-1:0] wb_tag,
   output logic             flush_done
);
   typedef struct packed {logic v; logic d; logic [TAG_W-1:0] t;} ent_t;
   typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;
   state_t state, state_n;
   ent_t mem [DEPTH][WAYS];
   ent_t row [WAYS];
   ent_t row_n [WAYS];
   ent_t cur, sel;
   logic [IDX_W-1:0] w_idx, scan_idx;
   logic [POS_W-1:0] scan_pos, match_pos;
   logic do_fill, do_touch, touch_ok, w_en, clr, last, match;

   assign busy       = state == SCAN || state == EMIT;
   assign wb_valid   = state == EMIT;
   assign flush_done = state == DONE;
   assign cur        = mem[scan_idx][scan_pos];
   assign wb_idx     = wb_valid ? scan_idx : '0;
   assign wb_tag     = wb_valid ? cur.t : '0;
   assign last       = scan_idx == IDX_W'(DEPTH-1) && scan_pos == POS_W'(WAYS-1);
   assign do_fill    = fill_en && !busy;
   assign do_touch   = touch_en && !busy && !fill_en;

   always_comb begin
      state_n = state;
      clr = 1'b0;
      if (state == IDLE) state_n = flush_req ? SCAN : IDLE;
      else if (state == SCAN) begin
         clr = !(cur.v && cur.d);
         state_n = !clr ? EMIT : last ? DONE : SCAN;
      end else if (state == EMIT) begin
         clr = wb_ready;
         state_n = !clr ? EMIT : last ? DONE : SCAN;
      end else state_n = IDLE;
   end

   // One set is rewritten per cycle: fill, touch, or the flush clearing the scanned entry.
   always_comb begin
      w_idx = do_fill ? fill_idx : do_touch ? touch_idx : scan_idx;
      for (int i = 0; i < WAYS; i++) row[i] = mem[w_idx][i];
      touch_ok = int'(touch_pos) < WAYS && row[touch_pos].v;
      sel = row[touch_pos];
      sel.d = sel.d | touch_wr;
      w_en = do_fill || (do_touch && touch_ok) || clr;
      for (int i = 0; i < WAYS; i++) row_n[i] = row[i];
      if (do_fill) begin
         row_n[0] = {1'b1, fill_dirty, fill_tag};
         for (int i = 1; i < WAYS; i++) row_n[i] = row[i-1];
      end else if (do_touch) begin
         row_n[0] = sel;
         for (int i = 1; i < WAYS; i++) if (i <= int'(touch_pos)) row_n[i] = row[i-1];
      end else row_n[scan_pos] = '0;
   end

   always_comb begin
      match = 1'b0;
      match_pos = '0;
      for (int i = WAYS-1; i >= 0; i--) begin
         if (mem[lk_idx][i].v && mem[lk_idx][i].t == lk_tag) begin
            match = 1'b1;
            match_pos = POS_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) state <= IDLE;
      else state <= state_n;
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         scan_idx  <= '0;
         scan_pos  <= '0;
         lk_vld    <= 1'b0;
         lk_hit    <= 1'b0;
         lk_pos    <= '0;
         vic_vld   <= 1'b0;
         vic_valid <= 1'b0;
         vic_dirty <= 1'b0;
         vic_tag   <= '0;
         for (int s = 0; s < DEPTH; s++)
            for (int i = 0; i < WAYS; i++) mem[s][i] <= '0;
      end else begin
         if (clr) begin
            scan_pos <= scan_pos == POS_W'(WAYS-1) ? '0 : scan_pos + 1'b1;
            if (scan_pos == POS_W'(WAYS-1)) scan_idx <= scan_idx + 1'b1;
         end
         if (w_en)
            for (int i = 0; i < WAYS; i++) mem[w_idx][i] <= row_n[i];
         lk_vld  <= lk_en;
         lk_hit  <= lk_en && !busy && match;
         lk_pos  <= (lk_en && !busy && match) ? match_pos : '0;
         vic_vld <= do_fill;
         if (do_fill) {vic_valid, vic_dirty, vic_tag} <= row[WAYS-1];
      end
   end
endmodule

// File: tb/tb_lru_tracker_nway.sv
// tb_lru_tracker_nway: random and directed stimulus against a queue-per-set recency model,
// with a decoupled monitor scoring lookup, victim and write-back outputs.
module tb_lru_tracker_nway;
   localparam int WAYS = 4, DEPTH = 64, TAG_W = 8;
   localparam int IDX_W = $clog2(DEPTH), POS_W = $clog2(WAYS);

   logic clk = 0, RST = 0;
   logic lk_en = 0, touch_en = 0, touch_wr = 0, fill_en = 0, fill_dirty = 0, flush_req = 0, wb_ready = 0;
   logic [IDX_W-1:0] lk_idx = '0, touch_idx = '0, fill_idx = '0;
   logic [TAG_W-1:0] lk_tag = '0, fill_tag = '0;
   logic [POS_W-1:0] touch_pos = '0;
   logic lk_vld, lk_hit, vic_vld, vic_valid, vic_dirty, busy, wb_valid, flush_done;
   logic [POS_W-1:0] lk_pos;
   logic [TAG_W-1:0] vic_tag, wb_tag;
   logic [IDX_W-1:0] wb_idx;

   lru_tracker_nway #(.WAYS(WAYS), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .RST(RST),
      .lk_en(lk_en), .lk_idx(lk_idx), .lk_tag(lk_tag), .lk_vld(lk_vld), .lk_hit(lk_hit), .lk_pos(lk_pos),
      .touch_en(touch_en), .touch_idx(touch_idx), .touch_pos(touch_pos), .touch_wr(touch_wr),
      .fill_en(fill_en), .fill_idx(fill_idx), .fill_tag(fill_tag), .fill_dirty(fill_dirty),
      .vic_vld(vic_vld), .vic_valid(vic_valid), .vic_dirty(vic_dirty), .vic_tag(vic_tag),
      .flush_req(flush_req), .busy(busy), .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_idx(wb_idx), .wb_tag(wb_tag), .flush_done(flush_done)
   );

   always #5 clk = ~clk;

   typedef struct {logic d; logic [TAG_W-1:0] t;} ln_t;
   ln_t sets [DEPTH][$];
   logic [POS_W:0] lk_q[$];
   logic [TAG_W+1:0] vic_q[$];
   logic [IDX_W+TAG_W-1:0] wb_q[$];
   int total = 0, passed = 0, done_cnt = 0;
   logic have_prev = 0;
   logic [IDX_W+TAG_W-1:0] prev;
   logic [POS_W:0] le;
   logic [TAG_W+1:0] ve;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      total++;
      if (a === e) passed++;
      else $display("FAIL %s: got %0h expected %0h", n, a, e);
   endtask

   // Monitor: samples 2ns after the falling edge so same-edge stimulus is settled.
   always @(negedge clk) begin
      #2;
      if (!RST) have_prev = 0;
      else begin
         if (lk_vld) begin
            if (lk_q.size() == 0) chk("lk_unexpected", 1, 0);
            else begin
               le = lk_q.pop_front();
               chk("lk_hit", lk_hit, le[POS_W]);
               if (le[POS_W]) chk("lk_pos", lk_pos, le[POS_W-1:0]);
            end
         end
         if (vic_vld) begin
            if (vic_q.size() == 0) chk("vic_unexpected", 1, 0);
            else begin
               ve = vic_q.pop_front();
               chk("vic_valid", vic_valid, ve[TAG_W+1]);
               if (ve[TAG_W+1]) begin
                  chk("vic_dirty", vic_dirty, ve[TAG_W]);
                  chk("vic_tag", vic_tag, ve[TAG_W-1:0]);
               end
            end
         end
         if (have_prev) chk("wb_hold", {wb_valid, wb_idx, wb_tag}, {1'b1, prev});
         if (wb_valid && wb_ready) begin
            if (wb_q.size() == 0) chk("wb_unexpected", 1, 0);
            else chk("wb_line", {wb_idx, wb_tag}, wb_q.pop_front());
         end
         have_prev = wb_valid && !wb_ready;
         prev = {wb_idx, wb_tag};
         if (flush_done) done_cnt++;
      end
   end

   task automatic op(input bit l, input int li, input logic [TAG_W-1:0] lt,
                     input bit f, input int fi, input logic [TAG_W-1:0] ft, input bit fd,
                     input bit t, input int ti, input int tp, input bit tw);
      ln_t x;
      bit h;
      int p;
      lk_en = l; lk_idx = IDX_W'(li); lk_tag = lt;
      fill_en = f; fill_idx = IDX_W'(fi); fill_tag = ft; fill_dirty = fd;
      touch_en = t; touch_idx = IDX_W'(ti); touch_pos = POS_W'(tp); touch_wr = tw;
      if (l) begin
         h = 0; p = 0;
         for (int k = 0; k < sets[li].size(); k++)
            if (!h && sets[li][k].t == lt) begin h = 1; p = k; end
         lk_q.push_back({h, POS_W'(p)});
      end
      if (f) begin
         if (sets[fi].size() == WAYS) begin
            x = sets[fi].pop_back();
            vic_q.push_back({1'b1, x.d, x.t});
         end else vic_q.push_back('0);
         x.d = fd; x.t = ft;
         sets[fi].push_front(x);
      end else if (t && tp < sets[ti].size()) begin
         x = sets[ti][tp];
         sets[ti].delete(tp);
         x.d = x.d | tw;
         sets[ti].push_front(x);
      end
      @(negedge clk);
      lk_en = 0; fill_en = 0; touch_en = 0;
   endtask

   task automatic model_flush();
      for (int s = 0; s < DEPTH; s++) begin
         for (int k = 0; k < sets[s].size(); k++)
            if (sets[s][k].d) wb_q.push_back({IDX_W'(s), sets[s][k].t});
         sets[s].delete();
      end
   endtask

   task automatic run_flush(input int stall, input bit inject, output int busy_c);
      int vc = 0;
      bit got = 0;
      flush_req = 1;
      model_flush();
      @(negedge clk);
      flush_req = 0;
      busy_c = 0;
      for (int k = 0; k < 4000 && !got; k++) begin
         if (busy) busy_c++;
         if (wb_valid) vc++;
         if (flush_done) got = 1;
         wb_ready = vc > stall;
         lk_en = inject && k == 10;
         fill_en = lk_en;
         lk_idx = IDX_W'(5); lk_tag = 8'h5A;
         fill_idx = IDX_W'(7); fill_tag = 8'h77; fill_dirty = 0;
         if (lk_en) lk_q.push_back('0);
         @(negedge clk);
      end
      lk_en = 0; fill_en = 0; wb_ready = 0;
      chk("flush_done_seen", got, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int bc;
      repeat (2) @(negedge clk);
      chk("rst_lk_vld", lk_vld, 0);
      chk("rst_lk_hit", lk_hit, 0);
      chk("rst_vic_vld", vic_vld, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_flush_done", flush_done, 0);
      RST = 1;
      @(negedge clk);
      op(0, 0, 0, 1, 3, 8'hA0, 0, 0, 0, 0, 0);
      op(0, 0, 0, 1, 3, 8'hB0, 0, 0, 0, 0, 0);
      op(0, 0, 0, 1, 3, 8'hC0, 0, 0, 0, 0, 0);
      op(0, 0, 0, 1, 3, 8'hD0, 0, 0, 0, 0, 0);
      op(1, 3, 8'hA0, 0, 0, 0, 0, 0, 0, 0, 0);
      op(0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 1);
      op(1, 3, 8'hA0, 0, 0, 0, 0, 0, 0, 0, 0);
      op(0, 0, 0, 1, 3, 8'hE0, 0, 0, 0, 0, 0);
      op(1, 3, 8'hC0, 1, 3, 8'hF0, 0, 0, 0, 0, 0);
      op(1, 3, 8'hE0, 1, 3, 8'h1F, 1, 1, 3, 2, 1);
      op(1, 3, 8'hE0, 0, 0, 0, 0, 0, 0, 0, 0);
      op(1, 3, 8'hA0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int n = 0; n < 400; n++)
         op($urandom_range(0, 1) == 1, $urandom_range(0, 7), TAG_W'($urandom_range(0, 15)),
            $urandom_range(0, 2) == 0, $urandom_range(0, 7), TAG_W'($urandom_range(1, 15)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
            $urandom_range(0, WAYS-1), $urandom_range(0, 1) == 1);
      run_flush(0, 0, bc);
      op(0, 0, 0, 1, 0, 8'h0D, 1, 0, 0, 0, 0);
      op(0, 0, 0, 1, 0, 8'h0C, 0, 0, 0, 0, 0);
      op(0, 0, 0, 1, 5, 8'h5A, 1, 0, 0, 0, 0);
      run_flush(3, 1, bc);
      chk("flush_cycles", bc, DEPTH*WAYS + 5);
      op(1, 0, 8'h0D, 0, 0, 0, 0, 0, 0, 0, 0);
      op(1, 0, 8'h0C, 0, 0, 0, 0, 0, 0, 0, 0);
      op(1, 5, 8'h5A, 0, 0, 0, 0, 0, 0, 0, 0);
      op(1, 7, 8'h77, 0, 0, 0, 0, 0, 0, 0, 0);
      op(0, 0, 0, 1, 2, 8'h2B, 1, 0, 0, 0, 0);
      flush_req = 1;
      model_flush();
      @(negedge clk);
      flush_req = 0;
      for (int k = 0; k < 400 && !wb_valid; k++) @(negedge clk);
      chk("emit_reached", wb_valid, 1);
      RST = 0;
      #1;
      chk("rst_mid_wb_valid", wb_valid, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_done", flush_done, 0);
      wb_q.delete();
      repeat (2) @(negedge clk);
      RST = 1;
      repeat (20) @(negedge clk);
      op(1, 2, 8'h2B, 0, 0, 0, 0, 0, 0, 0, 0);
      op(0, 0, 0, 1, 2, 8'h2C, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("lk_q_empty", lk_q.size(), 0);
      chk("vic_q_empty", vic_q.size(), 0);
      chk("wb_q_empty", wb_q.size(), 0);
      chk("flush_done_count", done_cnt, 2);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/lru_tracker_nway.md
Name: lru_tracker_nway

Overview:
Parametrised per-set true-LRU replacement tracker for the set-associative cache. It stores a recency-ordered list of {valid, dirty, tag} entries per set (position 0 = MRU, WAYS-1 = LRU) and provides tag lookup, hit promotion, fill with victim report, and a full-cache flush that emits dirty lines on a valid/ready write-back port. It sits between the PE request path (lookup/touch) and the memory refill path (fill, write-back).

Parameters:
WAYS, 4, associativity (entries per set), >=2
DEPTH, 64, number of sets, power of two
TAG_W, 8, stored tag width
IDX_W, $clog2(DEPTH), set index width (derived)
POS_W, $clog2(WAYS), recency position width (derived)

Ports:
clk  in  1  clock
RST  in  1  asynchronous, active-low reset
lk_en  in  1  lookup request
lk_idx  in  IDX_W  lookup set
lk_tag  in  TAG_W  lookup tag
lk_vld  out  1  lookup result valid (1 cycle after lk_en)
lk_hit  out  1  tag matched a valid entry
lk_pos  out  POS_W  recency position of match
touch_en  in  1  promote entry to MRU
touch_idx  in  IDX_W  set
touch_pos  in  POS_W  position to promote
touch_wr  in  1  1 = write access, set dirty
fill_en  in  1  insert new line
fill_idx  in  IDX_W  set
fill_tag  in  TAG_W  new tag
fill_dirty  in  1  initial dirty bit
vic_vld  out  1  victim report valid (1 cycle after accepted fill)
vic_valid  out  1  evicted entry valid bit
vic_dirty  out  1  evicted entry dirty bit
vic_tag  out  TAG_W  evicted tag
flush_req  in  1  start full flush (pulse)
busy  out  1  flush in progress
wb_valid  out  1  dirty line offered for write-back
wb_ready  in  1  consumer accepts write-back
wb_idx  out  IDX_W  set of dirty line
wb_tag  out  TAG_W  tag of dirty line
flush_done  out  1  one-cycle pulse at flush completion

Behaviour:
- Reset (RST=0, async): every entry valid=0, dirty=0, tag=0; FSM IDLE; all outputs 0.
- Lookup: state sampled before same-cycle updates; lk_vld/lk_hit/lk_pos registered next cycle. Multiple matches impossible by construction; if present, lowest position wins. lk_vld pulses even when busy, with lk_hit=0.
- Touch (accepted when !busy and !fill_en): pos p valid -> entry p to position 0, positions 0..p-1 shift down one, p+1..WAYS-1 unchanged; dirty |= touch_wr. p=0 updates dirty only. Invalid p or p>=WAYS: no change.
- Fill (accepted when !busy): entry at WAYS-1 reported on vic_* with vic_vld next cycle; all positions shift down one; position 0 = {1, fill_dirty, fill_tag}. Invalid entries therefore always occupy the bottom positions.
- Simultaneous fill and touch: fill executes, touch dropped (any index). Simultaneous flush_req and fill/touch: the op executes this cycle, flush starts next cycle.
- Flush FSM: IDLE -> SCAN on flush_req (busy=1 next cycle). SCAN visits set 0..DEPTH-1, position 0..WAYS-1, one entry per cycle. Valid&dirty -> EMIT: wb_valid=1 with wb_idx/wb_tag held stable until wb_ready; handshake cycle clears entry, returns to SCAN at next entry. Other entries cleared (valid=dirty=0) in the SCAN cycle. After last entry -> DONE: flush_done=1 one cycle, busy=0, then IDLE. Clean-cache flush = DEPTH*WAYS SCAN cycles.
- flush_req during busy: ignored. fill/touch during busy: ignored, no vic_vld.
- Reset mid-flush: immediate return to IDLE, wb_valid=0, no flush_done.

Test Plan:
- Reset, WAYS=4: fill set 3 with tags A,B,C,D -> four vic_vld with vic_valid=0; lookup A -> lk_hit=1, lk_pos=3.
- Touch set 3 pos 3 with touch_wr=1 -> order A,D,C,B, A dirty; fill E -> victim B, vic_valid=1, vic_dirty=0.
- Fill F after that ordering -> victim C; lookup same cycle as fill for C -> lk_hit=1, lk_pos=3 (pre-update state).
- Same-cycle fill_en and touch_en on set 3 -> only fill applied; next lookup shows touch had no effect.
- Two dirty lines (set 0 pos 1, set 5 pos 0), flush with wb_ready low 3 cycles on first -> wb_idx/wb_tag stable, two handshakes in order set 0 then 5, flush_done after DEPTH*WAYS+handshake stalls, all lookups then miss.
- Assert RST during EMIT -> wb_valid=0 and busy=0 immediately, no flush_done, all entries invalid.
